// File: rtl/usb_crc16_checker_if.sv
// usb_crc16_checker_if: receive-bit-stream bus between the USB RX datapath and the CRC-16 checker
//   clear        : restart accumulation at SEED (new packet)
//   shift_enable : d_orig carries a valid decoded stream bit this cycle
//   d_orig       : serial data bit, wire order (LSB-first)
//   crc_check_16 : high while the remainder equals the USB CRC-16 residual
interface usb_crc16_checker_if;
    logic clear;
    logic shift_enable;
    logic d_orig;
    logic crc_check_16;
    modport master (output clear, output shift_enable, output d_orig, input crc_check_16);
    modport slave (input clear, input shift_enable, input d_orig, output crc_check_16);
endinterface

// File: rtl/usb_crc16_checker.sv
// usb_crc16_checker: serial USB CRC-16 receive checker; flags a good packet residual
//   clk   : rising-edge clock
//   n_rst : asynchronous active-low reset, reloads SEED
//   bus   : usb_crc16_checker_if.slave (clear, shift_enable, d_orig in; crc_check_16 out)
// Build option USB_CRC16_CHECK_REG_EN: registers crc_check_16 from the next-state
// remainder, keeping the same edge timing but making the flag glitch-free.
module usb_crc16_checker #(
    parameter logic [15:0] POLY    = 16'h8005,
    parameter logic [15:0] SEED    = 16'hFFFF,
    parameter logic [15:0] RESIDUE = 16'h800D
) (
    input logic              clk,
    input logic              n_rst,
    usb_crc16_checker_if.slave bus
);
    logic [15:0] r_crc;
    logic [15:0] w_crc_next;
    logic        w_fb;
    always_comb begin
        w_fb       = bus.d_orig ^ r_crc[15];
        w_crc_next = bus.clear        ? SEED :
                     bus.shift_enable ? ({r_crc[14:0], 1'b0} ^ (w_fb ? POLY : 16'h0000)) :
                                        r_crc;
    end
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) r_crc <= SEED;
        else        r_crc <= w_crc_next;
    end
`ifdef USB_CRC16_CHECK_REG_EN
    logic r_check;
    // Compare against the next remainder so the flop rises on the same edge as the last shift.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst)         r_check <= 1'b0;
        else if (bus.clear) r_check <= 1'b0;
        else                r_check <= (w_crc_next == RESIDUE);
    end
    assign bus.crc_check_16 = r_check;
`else
    assign bus.crc_check_16 = (r_crc == RESIDUE);
`endif
endmodule

// File: tb/tb_usb_crc16_checker.sv
// tb_usb_crc16_checker: directed scoreboard bench for usb_crc16_checker
module tb_usb_crc16_checker;
    typedef struct {
        string tag;
        logic  val;
    } exp_t;
    localparam logic [0:47] GOOD = {16'b0000000010000000, 16'b0100000011000000, 16'b1111011101011110};
    logic clk;
    logic n_rst;
    int   checks;
    int   errors;
    exp_t sb[$];
    logic [0:47] bad;
    usb_crc16_checker_if bus ();
    usb_crc16_checker dut (.clk(clk), .n_rst(n_rst), .bus(bus));
    initial clk = 1'b0;
    always #5 clk = ~clk;
    task automatic expect_val(input string tag, input logic v);
        exp_t e;
        e.tag = tag;
        e.val = v;
        sb.push_back(e);
    endtask
    task automatic check_out();
        exp_t e;
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $error("FAIL scoreboard_empty observed=%b expected=none", bus.crc_check_16);
        end else begin
            e = sb.pop_front();
            assert (bus.crc_check_16 === e.val) else begin
                errors++;
                $error("FAIL %s observed=%b expected=%b", e.tag, bus.crc_check_16, e.val);
            end
        end
    endtask
    task automatic shift_bit(input logic b);
        bus.shift_enable = 1'b1;
        bus.d_orig       = b;
        @(posedge clk);
        #1;
    endtask
    task automatic idle();
        bus.shift_enable = 1'b0;
        bus.d_orig       = ~bus.d_orig;
        @(posedge clk);
        #1;
    endtask
    task automatic clear_pulse(input logic se);
        bus.clear        = 1'b1;
        bus.shift_enable = se;
        bus.d_orig       = 1'b1;
        @(posedge clk);
        #1;
        bus.clear        = 1'b0;
        bus.shift_enable = 1'b0;
    endtask
    task automatic feed(input logic [0:47] s, input int nbits, input int gap);
        for (int i = 0; i < nbits; i++) begin
            shift_bit(s[i]);
            if (gap > 0 && (i == 15 || i == 31)) repeat (gap) idle();
        end
        bus.shift_enable = 1'b0;
    endtask
    initial begin
        checks           = 0;
        errors           = 0;
        n_rst            = 1'b0;
        bus.clear        = 1'b0;
        bus.shift_enable = 1'b0;
        bus.d_orig       = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        expect_val("reset_state", 1'b0);
        check_out();
        #3 n_rst = 1'b1;
        repeat (3) idle();
        expect_val("idle_after_reset", 1'b0);
        check_out();
        expect_val("good_packet", 1'b1);
        feed(GOOD, 48, 0);
        check_out();
        repeat (3) idle();
        expect_val("hold_while_disabled", 1'b1);
        check_out();
        shift_bit(1'b0);
        bus.shift_enable = 1'b0;
        expect_val("drop_after_extra_bit", 1'b0);
        check_out();
        clear_pulse(1'b0);
        bad     = GOOD;
        bad[20] = ~bad[20];
        expect_val("corrupt_data_bit20", 1'b0);
        feed(bad, 48, 0);
        check_out();
        clear_pulse(1'b0);
        bad     = GOOD;
        bad[40] = ~bad[40];
        expect_val("corrupt_crc_bit40", 1'b0);
        feed(bad, 48, 0);
        check_out();
        clear_pulse(1'b0);
        expect_val("gapped_packet", 1'b1);
        feed(GOOD, 48, 3);
        check_out();
        clear_pulse(1'b0);
        feed(GOOD, 20, 0);
        clear_pulse(1'b1);
        expect_val("clear_restart", 1'b1);
        feed(GOOD, 48, 0);
        check_out();
        clear_pulse(1'b0);
        expect_val("clear_alone", 1'b0);
        check_out();
        feed(GOOD, 48, 0);
        #2 n_rst = 1'b0;
        #1;
        expect_val("async_reset_immediate", 1'b0);
        check_out();
        @(posedge clk);
        #1 n_rst = 1'b1;
        feed(GOOD, 20, 0);
        #2 n_rst = 1'b0;
        #2 n_rst = 1'b1;
        expect_val("good_after_midstream_reset", 1'b1);
        feed(GOOD, 48, 0);
        check_out();
        if (sb.size() != 0) begin
            checks++;
            errors++;
            $error("FAIL scoreboard_leftover observed=%0d expected=0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
